// File: rtl/hdmi_rx_timing_meter.sv
// Measures ADV7611 video timing in the pixel clock domain: line/frame totals, active sizes,
// lock detection over consecutive identical frames, and a VS-timeout no-signal flag.
module hdmi_rx_timing_meter #(
  parameter int unsigned CNT_W        = 12,
  parameter bit          HS_POL       = 1'b1,
  parameter bit          VS_POL       = 1'b1,
  parameter int unsigned LOCK_FRAMES  = 2,
  parameter int unsigned TIMEOUT_CLKS = 2000000
) (
  input  logic             hdmi_pclk_i,
  input  logic             reset,
  input  logic             hdmi_hs_i,
  input  logic             hdmi_vs_i,
  input  logic             hdmi_de_i,
  output logic [CNT_W-1:0] h_total_o,
  output logic [CNT_W-1:0] h_active_o,
  output logic [CNT_W-1:0] v_total_o,
  output logic [CNT_W-1:0] v_active_o,
  output logic             frame_done_o,
  output logic             locked_o,
  output logic             no_signal_o
);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam logic [3:0]  LockFrames  = 4'(LOCK_FRAMES);
  localparam logic [31:0] TimeoutClks = 32'(TIMEOUT_CLKS);

  function automatic cnt_t sat_inc(input cnt_t v);
    return (&v) ? v : v + cnt_t'(1);
  endfunction

  logic        hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q;
  logic        hs1_d, vs1_d, de1_d, hs2_d, vs2_d, de2_d;
  cnt_t        hcnt_q, hcnt_d, run_q, run_d, vcnt_q, vcnt_d;
  cnt_t        h_total_cur_q, h_total_cur_d, h_active_cur_q, h_active_cur_d;
  cnt_t        v_active_cur_q, v_active_cur_d;
  cnt_t        h_total_q, h_total_d, h_active_q, h_active_d;
  cnt_t        v_total_q, v_total_d, v_active_q, v_active_d;
  logic        frame_done_q, frame_done_d, locked_q, locked_d, no_signal_q, no_signal_d;
  logic        armed_q, armed_d;
  logic [3:0]  match_q, match_d;
  logic [31:0] tcnt_q, tcnt_d;

  logic hs_rise, vs_rise, de_rise, de_fall, same_tuple;
  cnt_t pub_ht, pub_ha, pub_vt, pub_va;

  assign hs_rise = hs1_q & ~hs2_q;
  assign vs_rise = vs1_q & ~vs2_q;
  assign de_rise = de1_q & ~de2_q;
  assign de_fall = ~de1_q & de2_q;

  // A DE line ending in the same cycle as VS still belongs to the closing frame.
  assign pub_ht = h_total_cur_q;
  assign pub_ha = de_fall ? run_q : h_active_cur_q;
  assign pub_va = de_fall ? sat_inc(v_active_cur_q) : v_active_cur_q;
  // vcnt holds the index of the last line; the frame has one more line than that.
  assign pub_vt = sat_inc(vcnt_q);

  assign same_tuple = (pub_ht == h_total_q) && (pub_ha == h_active_q) &&
                      (pub_vt == v_total_q) && (pub_va == v_active_q);

  always_comb begin
    hs1_d          = hdmi_hs_i ^ ~HS_POL;
    vs1_d          = hdmi_vs_i ^ ~VS_POL;
    de1_d          = hdmi_de_i;
    hs2_d          = hs1_q;
    vs2_d          = vs1_q;
    de2_d          = de1_q;
    hcnt_d         = sat_inc(hcnt_q);
    run_d          = run_q;
    vcnt_d         = vcnt_q;
    h_total_cur_d  = h_total_cur_q;
    h_active_cur_d = h_active_cur_q;
    v_active_cur_d = v_active_cur_q;
    h_total_d      = h_total_q;
    h_active_d     = h_active_q;
    v_total_d      = v_total_q;
    v_active_d     = v_active_q;
    frame_done_d   = 1'b0;
    locked_d       = locked_q;
    no_signal_d    = no_signal_q;
    armed_d        = armed_q;
    match_d        = match_q;
    tcnt_d         = (tcnt_q == TimeoutClks) ? tcnt_q : tcnt_q + 32'd1;

    if (hs_rise) begin
      h_total_cur_d = sat_inc(hcnt_q);
      hcnt_d        = '0;
      vcnt_d        = sat_inc(vcnt_q);
    end

    if (de_rise) begin
      run_d = cnt_t'(1);
    end else if (de1_q) begin
      run_d = sat_inc(run_q);
    end

    if (de_fall) begin
      h_active_cur_d = run_q;
      v_active_cur_d = sat_inc(v_active_cur_q);
    end

    if (vs_rise) begin
      tcnt_d         = '0;
      no_signal_d    = 1'b0;
      armed_d        = 1'b1;
      vcnt_d         = '0;
      h_active_cur_d = '0;
      v_active_cur_d = '0;
      if (armed_q) begin
        h_total_d    = pub_ht;
        h_active_d   = pub_ha;
        v_total_d    = pub_vt;
        v_active_d   = pub_va;
        frame_done_d = 1'b1;
        if (same_tuple) begin
          match_d  = (match_q == LockFrames) ? match_q : match_q + 4'd1;
          locked_d = (match_d == LockFrames);
        end else begin
          match_d  = '0;
          locked_d = 1'b0;
        end
      end
    end else if (tcnt_d == TimeoutClks) begin
      no_signal_d = 1'b1;
      locked_d    = 1'b0;
      h_total_d   = '0;
      h_active_d  = '0;
      v_total_d   = '0;
      v_active_d  = '0;
      match_d     = '0;
      armed_d     = 1'b0;
    end
  end

  always_ff @(posedge hdmi_pclk_i) begin
    if (reset) begin
      {hs1_q, vs1_q, de1_q, hs2_q, vs2_q, de2_q} <= '0;
      hcnt_q         <= '0;
      run_q          <= '0;
      vcnt_q         <= '0;
      h_total_cur_q  <= '0;
      h_active_cur_q <= '0;
      v_active_cur_q <= '0;
      h_total_q      <= '0;
      h_active_q     <= '0;
      v_total_q      <= '0;
      v_active_q     <= '0;
      frame_done_q   <= 1'b0;
      locked_q       <= 1'b0;
      no_signal_q    <= 1'b0;
      armed_q        <= 1'b0;
      match_q        <= '0;
      tcnt_q         <= '0;
    end else begin
      {hs1_q, vs1_q, de1_q} <= {hs1_d, vs1_d, de1_d};
      {hs2_q, vs2_q, de2_q} <= {hs2_d, vs2_d, de2_d};
      hcnt_q         <= hcnt_d;
      run_q          <= run_d;
      vcnt_q         <= vcnt_d;
      h_total_cur_q  <= h_total_cur_d;
      h_active_cur_q <= h_active_cur_d;
      v_active_cur_q <= v_active_cur_d;
      h_total_q      <= h_total_d;
      h_active_q     <= h_active_d;
      v_total_q      <= v_total_d;
      v_active_q     <= v_active_d;
      frame_done_q   <= frame_done_d;
      locked_q       <= locked_d;
      no_signal_q    <= no_signal_d;
      armed_q        <= armed_d;
      match_q        <= match_d;
      tcnt_q         <= tcnt_d;
    end
  end

  assign h_total_o    = h_total_q;
  assign h_active_o   = h_active_q;
  assign v_total_o    = v_total_q;
  assign v_active_o   = v_active_q;
  assign frame_done_o = frame_done_q;
  assign locked_o     = locked_q;
  assign no_signal_o  = no_signal_q;

endmodule

// File: tb/tb_hdmi_rx_timing_meter.sv
// Bench for hdmi_rx_timing_meter: three instances (positive sync, inverted sync, 8-bit counters)
// driven with randomized frame geometries and checked against a frame-level reference model.
module tb_hdmi_rx_timing_meter;

  localparam int unsigned LockFrames  = 2;
  localparam int unsigned TimeoutClks = 5000;

  typedef struct { int ht; int ha; int vt; int va; } tup_t;
  typedef struct {
    int htot; int hsw; int hstart; int hact; int vtot; int vsw; int vstart; int vact;
  } geom_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs = 1'b0, vs = 1'b0, de = 1'b0;

  logic [11:0] p_ht, p_ha, p_vt, p_va, n_ht, n_ha, n_vt, n_va;
  logic [7:0]  s_ht, s_ha, s_vt, s_va;
  logic        p_fd, p_lk, p_ns, n_fd, n_lk, n_ns, s_fd, s_lk, s_ns;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_fd_cyc = 0;
  tup_t hist[$];
  tup_t pub_m, last_t;
  tup_t zt = '{default: 0};
  bit   armed_m = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hdmi_rx_timing_meter #(
    .CNT_W(12), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(LockFrames),
    .TIMEOUT_CLKS(TimeoutClks)
  ) u_pos (
    .hdmi_pclk_i(clk), .reset(rst), .hdmi_hs_i(hs), .hdmi_vs_i(vs), .hdmi_de_i(de),
    .h_total_o(p_ht), .h_active_o(p_ha), .v_total_o(p_vt), .v_active_o(p_va),
    .frame_done_o(p_fd), .locked_o(p_lk), .no_signal_o(p_ns)
  );

  hdmi_rx_timing_meter #(
    .CNT_W(12), .HS_POL(1'b0), .VS_POL(1'b0), .LOCK_FRAMES(LockFrames),
    .TIMEOUT_CLKS(TimeoutClks)
  ) u_neg (
    .hdmi_pclk_i(clk), .reset(rst), .hdmi_hs_i(~hs), .hdmi_vs_i(~vs), .hdmi_de_i(de),
    .h_total_o(n_ht), .h_active_o(n_ha), .v_total_o(n_vt), .v_active_o(n_va),
    .frame_done_o(n_fd), .locked_o(n_lk), .no_signal_o(n_ns)
  );

  hdmi_rx_timing_meter #(
    .CNT_W(8), .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_FRAMES(LockFrames),
    .TIMEOUT_CLKS(TimeoutClks)
  ) u_sat (
    .hdmi_pclk_i(clk), .reset(rst), .hdmi_hs_i(hs), .hdmi_vs_i(vs), .hdmi_de_i(de),
    .h_total_o(s_ht), .h_active_o(s_ha), .v_total_o(s_vt), .v_active_o(s_va),
    .frame_done_o(s_fd), .locked_o(s_lk), .no_signal_o(s_ns)
  );

  function automatic int sat(input int v, input int w);
    int m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  function automatic bit tup_eq(input tup_t a, input tup_t b, input int w);
    return (sat(a.ht, w) == sat(b.ht, w)) && (sat(a.ha, w) == sat(b.ha, w)) &&
           (sat(a.vt, w) == sat(b.vt, w)) && (sat(a.va, w) == sat(b.va, w));
  endfunction

  // Locked once the newest published tuple equals the LockFrames tuples before it.
  function automatic bit exp_lock(input int w);
    int n = hist.size();
    if (n < int'(LockFrames) + 1) return 1'b0;
    for (int k = 1; k <= int'(LockFrames); k++)
      if (!tup_eq(hist[n-1-k], hist[n-1], w)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic tup_t to_tup(input geom_t g);
    tup_t t;
    t.ht = g.htot;
    t.ha = (g.vact > 0) ? g.hact : 0;
    t.vt = g.vtot;
    t.va = g.vact;
    return t;
  endfunction

  function automatic geom_t rand_geom();
    geom_t g;
    g.htot   = $urandom_range(80, 40);
    g.hsw    = $urandom_range(10, 4);
    g.hstart = g.hsw + $urandom_range(5, 1);
    g.hact   = $urandom_range(g.htot - g.hstart - 1, 10);
    g.vtot   = $urandom_range(16, 10);
    g.vsw    = $urandom_range(3, 1);
    g.vstart = g.vsw + $urandom_range(2, 1);
    g.vact   = $urandom_range(g.vtot - g.vstart - 1, 3);
    return g;
  endfunction

  task automatic clear_model();
    hist.delete();
    hist.push_back(zt);
    pub_m   = zt;
    armed_m = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string who, input int w, input logic [31:0] ht,
                           input logic [31:0] ha, input logic [31:0] vt, input logic [31:0] va,
                           input logic lk, input logic ns, input tup_t t, input bit ens);
    check({who, ".h_total"}, ht, sat(t.ht, w));
    check({who, ".h_active"}, ha, sat(t.ha, w));
    check({who, ".v_total"}, vt, sat(t.vt, w));
    check({who, ".v_active"}, va, sat(t.va, w));
    check({who, ".locked"}, 32'(lk), 32'(exp_lock(w)));
    check({who, ".no_signal"}, 32'(ns), 32'(ens));
  endtask

  task automatic check_all(input tup_t t, input bit ens);
    check_dut("pos", 12, 32'(p_ht), 32'(p_ha), 32'(p_vt), 32'(p_va), p_lk, p_ns, t, ens);
    check_dut("neg", 12, 32'(n_ht), 32'(n_ha), 32'(n_vt), 32'(n_va), n_lk, n_ns, t, ens);
    check_dut("sat", 8, 32'(s_ht), 32'(s_ha), 32'(s_vt), 32'(s_va), s_lk, s_ns, t, ens);
  endtask

  // One frame; VS and HS lead at pixel 0 of line 0. rst_at >= 0 pulses reset at that pixel.
  task automatic run_frame(input geom_t g, input int rst_at);
    int np = 0, nn = 0, nsat = 0;
    bit will_pub = armed_m;
    bit did_rst = 1'b0;
    if (will_pub) begin
      hist.push_back(last_t);
      pub_m = last_t;
    end
    for (int l = 0; l < g.vtot; l++) begin
      for (int p = 0; p < g.htot; p++) begin
        @(posedge clk);
        #1;
        np += int'(p_fd);
        nn += int'(n_fd);
        nsat += int'(s_fd);
        if (p_fd) begin
          last_fd_cyc = cyc;
          check_all(pub_m, 1'b0);
        end
        if (rst) begin
          rst = 1'b0;
          check_all(zt, 1'b0);
        end
        if (l * g.htot + p == rst_at) begin
          rst = 1'b1;
          did_rst = 1'b1;
          clear_model();
        end
        hs = (p < g.hsw);
        vs = (l < g.vsw);
        de = (l >= g.vstart) && (l < g.vstart + g.vact) &&
             (p >= g.hstart) && (p < g.hstart + g.hact);
      end
    end
    check("frame_done_count.pos", 32'(np), 32'(will_pub));
    check("frame_done_count.neg", 32'(nn), 32'(will_pub));
    check("frame_done_count.sat", 32'(nsat), 32'(will_pub));
    check_all(pub_m, 1'b0);
    armed_m = !did_rst;
    last_t  = to_tup(g);
  endtask

  task automatic wait_timeout();
    bit seen = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    de = 1'b0;
    for (int i = 0; i < int'(TimeoutClks) + 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (p_ns) begin
        seen = 1'b1;
        check("no_signal_delay", 32'(cyc - last_fd_cyc), 32'(TimeoutClks));
        clear_model();
        check_all(zt, 1'b1);
      end
    end
    check("no_signal_seen", 32'(seen), 32'd1);
    clear_model();
  endtask

  initial begin
    geom_t ga, gb, gc, gd, gs;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_all(zt, 1'b0);
    rst = 1'b0;

    ga = rand_geom();
    gb = ga;
    gb.htot = ga.htot + $urandom_range(10, 1);
    gc = rand_geom();
    gc.vact = 0;
    gd = rand_geom();
    gd.hact = gd.htot - gd.hstart;
    gd.vact = gd.vtot - gd.vstart;
    gs = '{300, 20, 25, 270, 6, 1, 2, 3};

    repeat (5) run_frame(ga, -1);
    repeat (4) run_frame(gb, -1);
    repeat (3) run_frame(gc, -1);
    repeat (3) run_frame(gd, -1);
    run_frame(gd, gd.htot * (gd.vtot / 2) + 3);
    repeat (3) run_frame(gd, -1);
    repeat (3) run_frame(gs, -1);
    repeat (4) run_frame(ga, -1);
    wait_timeout();
    repeat (4) run_frame(ga, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
